// File: rtl/fpu_pkg.sv
// Shared FP32 field layout, special encodings and operation codes.
package fpu_pkg;

    localparam int unsigned SIGN_BIT = 31;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MAN_W    = 23;

    localparam logic [EXP_W-1:0] EXP_MAX   = 8'hFF;
    localparam logic [31:0]      FP32_QNAN = 32'h7FC00000;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

endpackage

// File: rtl/fpu_special_detect.sv
// Classifies the adder operands and picks the result for zero/Inf/NaN cases
// that the hidden-1 datapath cannot produce.
module fpu_special_detect
    import fpu_pkg::*;
#(
    parameter int unsigned NUM_OP = 1
) (
    input  logic [NUM_OP-1:0] i_op,
    input  logic [31:0]       i_a,
    input  logic [31:0]       i_b,
    output logic              o_special,
    output logic [31:0]       o_result
);

    fp32_t w_a;
    fp32_t w_b;
    logic  w_sa;
    logic  w_sb;
    logic  w_nan_a;
    logic  w_nan_b;
    logic  w_inf_a;
    logic  w_inf_b;
    logic  w_zero_a;
    logic  w_zero_b;

    assign w_a      = fp32_t'(i_a);
    assign w_b      = fp32_t'(i_b);
    assign w_sa     = i_a[SIGN_BIT];
    // Subtraction is addition with B's sign flipped.
    assign w_sb     = i_b[SIGN_BIT] ^ (i_op[0] == OP_SUB);
    assign w_nan_a  = (w_a.exp == EXP_MAX) && (w_a.man != '0);
    assign w_nan_b  = (w_b.exp == EXP_MAX) && (w_b.man != '0);
    assign w_inf_a  = (w_a.exp == EXP_MAX) && (w_a.man == '0);
    assign w_inf_b  = (w_b.exp == EXP_MAX) && (w_b.man == '0);
    assign w_zero_a = (w_a.exp == '0);
    assign w_zero_b = (w_b.exp == '0);

    // Priority-ordered special-result selection; falls through to the adder.
    always_comb begin
        o_special = 1'b1;
        o_result  = '0;
        if (w_nan_a || w_nan_b) begin
            o_result = FP32_QNAN;
        end else if (w_inf_a && w_inf_b && (w_sa != w_sb)) begin
            o_result = FP32_QNAN;
        end else if (w_inf_a) begin
            o_result = i_a;
        end else if (w_inf_b) begin
            o_result = {w_sb, i_b[30:0]};
        end else if (w_zero_a && w_zero_b) begin
            o_result = {w_sa & w_sb, 31'b0};
        end else if (w_zero_a) begin
            o_result = {w_sb, i_b[30:0]};
        end else if (w_zero_b) begin
            o_result = i_a;
        end else begin
            o_special = 1'b0;
        end
    end

endmodule

// File: rtl/fpu_addsub_issue.sv
// Issue/retire stage around the combinational FP32 adder: operation FIFO,
// special-case resolution, registered result with valid/ready, sticky flags.
module fpu_addsub_issue
    import fpu_pkg::*;
#(
    parameter int unsigned NUM_OP     = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [NUM_OP-1:0]              i_add_sub,
    input  logic [31:0]                    i_32_a,
    input  logic [31:0]                    i_32_b,
    output logic [NUM_OP-1:0]              o_fpu_add_sub,
    output logic [31:0]                    o_fpu_32_a,
    output logic [31:0]                    o_fpu_32_b,
    input  logic [31:0]                    i_fpu_32_s,
    input  logic                           i_fpu_ov_flag,
    input  logic                           i_fpu_un_flag,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [31:0]                    o_32_s,
    output logic                           o_ov_flag,
    output logic                           o_un_flag,
    output logic                           o_special,
    output logic                           o_sticky_ov,
    output logic                           o_sticky_un,
    input  logic                           i_clr_sticky,
    output logic [$clog2(FIFO_DEPTH):0]    o_count
);

    localparam int unsigned   PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    logic [NUM_OP-1:0] r_op_mem [FIFO_DEPTH];
    logic [31:0]       r_a_mem  [FIFO_DEPTH];
    logic [31:0]       r_b_mem  [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              r_ready;
    logic              r_valid;
    logic [31:0]       r_s;
    logic              r_ov;
    logic              r_un;
    logic              r_special;
    logic              r_sticky_ov;
    logic              r_sticky_un;

    logic              w_head_valid;
    logic              w_push;
    logic              w_pop;
    logic [PTR_W:0]    w_count_next;
    logic              w_det_special;
    logic [31:0]       w_det_result;
    logic [31:0]       w_res_s;
    logic              w_res_ov;
    logic              w_res_un;

    assign w_head_valid = (r_count != '0);
    assign w_push       = i_valid & r_ready;
    assign w_pop        = w_head_valid & (~r_valid | i_ready);

    // FIFO head goes straight to the adder; zeros while empty.
    assign o_fpu_add_sub = w_head_valid ? r_op_mem[r_rd_ptr] : '0;
    assign o_fpu_32_a    = w_head_valid ? r_a_mem[r_rd_ptr]  : '0;
    assign o_fpu_32_b    = w_head_valid ? r_b_mem[r_rd_ptr]  : '0;

    fpu_special_detect #(
        .NUM_OP (NUM_OP)
    ) u_detect (
        .i_op      (o_fpu_add_sub),
        .i_a       (o_fpu_32_a),
        .i_b       (o_fpu_32_b),
        .o_special (w_det_special),
        .o_result  (w_det_result)
    );

    // Special cases override the adder and suppress its flags.
    assign w_res_s  = w_det_special ? w_det_result : i_fpu_32_s;
    assign w_res_ov = ~w_det_special & i_fpu_ov_flag;
    assign w_res_un = ~w_det_special & i_fpu_un_flag;

    // Next occupancy from push/pop.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + (PTR_W+1)'(1);
            2'b01:   w_count_next = r_count - (PTR_W+1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    // FIFO storage write; contents need no reset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_op_mem[r_wr_ptr] <= i_add_sub;
            r_a_mem[r_wr_ptr]  <= i_32_a;
            r_b_mem[r_wr_ptr]  <= i_32_b;
        end
    end

    // FIFO pointers, occupancy and the registered not-full indication.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_next;
            r_ready <= (w_count_next < DEPTH_C);
        end
    end

    // Output register: load on pop, hold until the consumer takes it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid   <= 1'b0;
            r_s       <= '0;
            r_ov      <= 1'b0;
            r_un      <= 1'b0;
            r_special <= 1'b0;
        end else if (w_pop) begin
            r_valid   <= 1'b1;
            r_s       <= w_res_s;
            r_ov      <= w_res_ov;
            r_un      <= w_res_un;
            r_special <= w_det_special;
        end else if (i_ready) begin
            r_valid   <= 1'b0;
        end
    end

    // Sticky status: clear drops the old value, a same-cycle load still sets.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sticky_ov <= 1'b0;
            r_sticky_un <= 1'b0;
        end else begin
            r_sticky_ov <= (r_sticky_ov & ~i_clr_sticky) | (w_pop & w_res_ov);
            r_sticky_un <= (r_sticky_un & ~i_clr_sticky) | (w_pop & w_res_un);
        end
    end

    assign o_ready     = r_ready;
    assign o_count     = r_count;
    assign o_valid     = r_valid;
    assign o_32_s      = r_s;
    assign o_ov_flag   = r_ov;
    assign o_un_flag   = r_un;
    assign o_special   = r_special;
    assign o_sticky_ov = r_sticky_ov;
    assign o_sticky_un = r_sticky_un;

endmodule

// File: tb/tb_fpu_addsub_issue.sv
// Self-checking bench for fpu_addsub_issue: directed vector table, handshake
// corner sequences and a randomized run against a queue-based model.
module tb_fpu_addsub_issue;

    localparam int unsigned NUM_OP = 1;
    localparam int unsigned DEPTH  = 4;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [0:0]  i_add_sub;
    logic [31:0] i_32_a;
    logic [31:0] i_32_b;
    logic [0:0]  o_fpu_add_sub;
    logic [31:0] o_fpu_32_a;
    logic [31:0] o_fpu_32_b;
    logic [31:0] i_fpu_32_s;
    logic        i_fpu_ov_flag;
    logic        i_fpu_un_flag;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_32_s;
    logic        o_ov_flag;
    logic        o_un_flag;
    logic        o_special;
    logic        o_sticky_ov;
    logic        o_sticky_un;
    logic        i_clr_sticky;
    logic [2:0]  o_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fpu_addsub_issue #(.NUM_OP(NUM_OP), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_add_sub(i_add_sub), .i_32_a(i_32_a), .i_32_b(i_32_b),
        .o_fpu_add_sub(o_fpu_add_sub), .o_fpu_32_a(o_fpu_32_a), .o_fpu_32_b(o_fpu_32_b),
        .i_fpu_32_s(i_fpu_32_s), .i_fpu_ov_flag(i_fpu_ov_flag), .i_fpu_un_flag(i_fpu_un_flag),
        .o_valid(o_valid), .i_ready(i_ready), .o_32_s(o_32_s),
        .o_ov_flag(o_ov_flag), .o_un_flag(o_un_flag), .o_special(o_special),
        .o_sticky_ov(o_sticky_ov), .o_sticky_un(o_sticky_un),
        .i_clr_sticky(i_clr_sticky), .o_count(o_count)
    );

    // Stand-in adder: a fixed scrambling of the operands, with 1.0+2.0 exact.
    function automatic logic [31:0] mock_sum(input logic op, input logic [31:0] a, input logic [31:0] b);
        if (!op && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        return a ^ {b[15:0], b[31:16]} ^ {31'd0, op};
    endfunction

    assign i_fpu_32_s    = mock_sum(o_fpu_add_sub[0], o_fpu_32_a, o_fpu_32_b);
    assign i_fpu_ov_flag = (o_fpu_32_a[3:0] == 4'hA);
    assign i_fpu_un_flag = (o_fpu_32_a[3:0] == 4'h5);

    typedef struct {
        logic [31:0] s;
        logic        ov;
        logic        un;
        logic        sp;
    } res_t;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic        sp;
        logic        ov;
    } vec_t;

    // Expected result straight from the operand classification rules.
    function automatic res_t ref_resolve(input logic op, input logic [31:0] a, input logic [31:0] b);
        res_t r;
        logic sa, sb;
        bit a_nan, b_nan, a_inf, b_inf, a_z, b_z;
        sa    = a[31];
        sb    = b[31] ^ op;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        a_z   = (a[30:23] == 8'h00);
        b_z   = (b[30:23] == 8'h00);
        r.ov = 1'b0; r.un = 1'b0; r.sp = 1'b1;
        if (a_nan || b_nan)                   r.s = 32'h7FC00000;
        else if (a_inf && b_inf && sa != sb)  r.s = 32'h7FC00000;
        else if (a_inf)                       r.s = a;
        else if (b_inf)                       r.s = {sb, b[30:0]};
        else if (a_z && b_z)                  r.s = {sa & sb, 31'd0};
        else if (a_z)                         r.s = {sb, b[30:0]};
        else if (b_z)                         r.s = a;
        else begin
            r.s  = mock_sum(op, a, b);
            r.ov = (a[3:0] == 4'hA);
            r.un = (a[3:0] == 4'h5);
            r.sp = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [31:0] gen_fp();
        logic [31:0] v;
        int unsigned k;
        v = $urandom();
        k = $urandom_range(0, 9);
        case (k)
            0: v[30:0] = 31'd0;
            1: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
            2: begin v[30:23] = 8'hFF; if (v[22:0] == 0) v[0] = 1'b1; end
            3: v[30:23] = 8'h00;
            default: v[30:23] = 8'($urandom_range(1, 254));
        endcase
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        i_valid = 1'b0; i_add_sub = '0; i_32_a = '0; i_32_b = '0; i_clr_sticky = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst = 1'b1; idle();
        @(negedge clk);
        i_rst = 1'b0;
    endtask

    // One op into an idle pipe with the consumer ready: result at t+2.
    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        i_ready = 1'b1; i_valid = 1'b1; i_add_sub = v.op; i_32_a = v.a; i_32_b = v.b;
        @(negedge clk);
        idle();
        check($sformatf("vec%0d_t1_valid", idx), 32'(o_valid), 32'd0);
        @(negedge clk);
        check($sformatf("vec%0d_valid", idx),   32'(o_valid),   32'd1);
        check($sformatf("vec%0d_s", idx),       o_32_s,         v.s);
        check($sformatf("vec%0d_special", idx), 32'(o_special), 32'(v.sp));
        check($sformatf("vec%0d_ov", idx),      32'(o_ov_flag), 32'(v.ov));
    endtask

    vec_t   vecs[12];
    op_t    q[$];
    op_t    ops[6];
    res_t   m_out;
    res_t   r;
    logic   m_valid, m_sov, m_sun;
    bit     push, pop;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        i_rst = 1'b1; i_ready = 1'b0; idle();
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        check("rst_valid",   32'(o_valid),     32'd0);
        check("rst_s",       o_32_s,           32'd0);
        check("rst_count",   32'(o_count),     32'd0);
        check("rst_ready",   32'(o_ready),     32'd1);
        check("rst_special", 32'(o_special),   32'd0);
        check("rst_sticky",  32'({o_sticky_ov, o_sticky_un}), 32'd0);
        check("rst_ovun",    32'({o_ov_flag, o_un_flag}), 32'd0);
        check("rst_head_a",  o_fpu_32_a,       32'd0);

        // Directed vectors: {op, a, b, expected s, special, ov}.
        vecs[0]  = '{1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'h00000000, 32'h3F800000, 32'hBF800000, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 32'h3F800000, 32'hFF800000, 32'hFF800000, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 32'h3F800000, 32'hFF800000, 32'h7F800000, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 32'hFF800000, 32'h7F800000, 32'h7FC00000, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 32'h3F80000A, 32'h40000000, 32'h3F80400A, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 32'h3F800000, 32'h00012345, 32'h3F800000, 1'b1, 1'b0};
        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Backpressure: six back-to-back offers with the consumer stalled.
        do_reset();
        i_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            ops[k] = '{1'b0, 32'h40000000 + 32'(k << 4), 32'h3F800000 + 32'(k << 8)};
            @(negedge clk);
            check($sformatf("bp_ready%0d", k), 32'(o_ready), (k < 5) ? 32'd1 : 32'd0);
            i_valid = 1'b1; i_add_sub = ops[k].op; i_32_a = ops[k].a; i_32_b = ops[k].b;
        end
        @(negedge clk);
        idle();
        check("bp_count", 32'(o_count), 32'd4);
        check("bp_ready", 32'(o_ready), 32'd0);
        i_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            r = ref_resolve(ops[k].op, ops[k].a, ops[k].b);
            check($sformatf("drain%0d_valid", k), 32'(o_valid), 32'd1);
            check($sformatf("drain%0d_s", k), o_32_s, r.s);
            @(negedge clk);
        end
        check("drain_done_valid", 32'(o_valid), 32'd0);

        // Overflow on the middle of three ops, then sticky clear.
        do_reset();
        i_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k < 3) begin
                i_valid = 1'b1; i_add_sub = 1'b0;
                i_32_a = (k == 1) ? 32'h4080000A : 32'h40800000; i_32_b = 32'h40400000;
            end else idle();
            if (k >= 2) begin
                check($sformatf("ov_res%0d_valid", k - 2), 32'(o_valid), 32'd1);
                check($sformatf("ov_res%0d_flag", k - 2), 32'(o_ov_flag), (k == 3) ? 32'd1 : 32'd0);
                check($sformatf("ov_res%0d_sticky", k - 2), 32'(o_sticky_ov), (k >= 3) ? 32'd1 : 32'd0);
            end
        end
        @(negedge clk);
        check("sticky_hold", 32'(o_sticky_ov), 32'd1);
        i_clr_sticky = 1'b1;
        @(negedge clk);
        i_clr_sticky = 1'b0;
        check("sticky_clr", 32'(o_sticky_ov), 32'd0);

        // Reset with three ops queued and a result held.
        do_reset();
        i_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            i_valid = 1'b1; i_add_sub = 1'b0;
            i_32_a = (k == 0) ? 32'h4000000A : 32'h40000010; i_32_b = 32'h40000000;
        end
        @(negedge clk);
        idle();
        check("pre_rst_count", 32'(o_count), 32'd3);
        check("pre_rst_valid", 32'(o_valid), 32'd1);
        check("pre_rst_sticky", 32'(o_sticky_ov), 32'd1);
        i_rst = 1'b1; i_ready = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check("mid_rst_valid",  32'(o_valid), 32'd0);
        check("mid_rst_count",  32'(o_count), 32'd0);
        check("mid_rst_ready",  32'(o_ready), 32'd1);
        check("mid_rst_sticky", 32'({o_sticky_ov, o_sticky_un}), 32'd0);

        // Randomized traffic against the queue model.
        do_reset();
        q.delete(); m_valid = 1'b0; m_sov = 1'b0; m_sun = 1'b0;
        m_out = '{32'd0, 1'b0, 1'b0, 1'b0};
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            check("rnd_valid", 32'(o_valid), 32'(m_valid));
            check("rnd_count", 32'(o_count), 32'(q.size()));
            check("rnd_ready", 32'(o_ready), (q.size() < DEPTH) ? 32'd1 : 32'd0);
            check("rnd_head_a", o_fpu_32_a, (q.size() > 0) ? q[0].a : 32'd0);
            check("rnd_sticky", 32'({o_sticky_ov, o_sticky_un}), 32'({m_sov, m_sun}));
            if (m_valid) begin
                check("rnd_s", o_32_s, m_out.s);
                check("rnd_flags", 32'({o_special, o_ov_flag, o_un_flag}), 32'({m_out.sp, m_out.ov, m_out.un}));
            end
            i_valid      = ($urandom_range(0, 9) < 6);
            i_ready      = ($urandom_range(0, 9) < 6);
            i_clr_sticky = ($urandom_range(0, 19) == 0);
            i_add_sub    = 1'($urandom_range(0, 1));
            i_32_a       = gen_fp();
            i_32_b       = gen_fp();
            push = i_valid && (q.size() < DEPTH);
            pop  = (q.size() > 0) && (!m_valid || i_ready);
            if (i_clr_sticky) begin m_sov = 1'b0; m_sun = 1'b0; end
            if (pop) begin
                m_out = ref_resolve(q[0].op, q[0].a, q[0].b);
                void'(q.pop_front());
                m_valid = 1'b1;
                m_sov = m_sov | m_out.ov;
                m_sun = m_sun | m_out.un;
            end else if (i_ready) begin
                m_valid = 1'b0;
            end
            if (push) q.push_back('{i_add_sub[0], i_32_a, i_32_b});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_addsub_issue.md
Name: fpu_addsub_issue

Overview:
Sequential issue/retire stage wrapped around the combinational FP32 add/sub datapath.
- Accepts operations from a producer over valid/ready and buffers them in a small FIFO.
- Presents the FIFO head to the adder, resolves zero/Inf/NaN operands that the adder cannot handle (it forces the hidden 1), and registers the result for a valid/ready consumer.
- Keeps sticky overflow/underflow status.

Parameters:
NUM_OP, 1, width of the operation select (bit 0: 0 = add, 1 = subtract)
FIFO_DEPTH, 4, operation FIFO entries; power of 2, at least 2
PTR_W, $clog2(FIFO_DEPTH), FIFO pointer width (derived, not overridden)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_valid  in  1  producer has an operation
o_ready  out  1  FIFO can accept an operation
i_add_sub  in  NUM_OP  operation select
i_32_a  in  32  operand A, FP32
i_32_b  in  32  operand B, FP32
o_fpu_add_sub  out  NUM_OP  FIFO head operation select, to adder
o_fpu_32_a  out  32  FIFO head operand A, to adder
o_fpu_32_b  out  32  FIFO head operand B, to adder
i_fpu_32_s  in  32  adder result
i_fpu_ov_flag  in  1  adder overflow flag
i_fpu_un_flag  in  1  adder underflow flag
o_valid  out  1  output register holds a result
i_ready  in  1  consumer accepts the result
o_32_s  out  32  registered result
o_ov_flag  out  1  registered overflow flag
o_un_flag  out  1  registered underflow flag
o_special  out  1  result came from the special-case path
o_sticky_ov  out  1  sticky overflow status
o_sticky_un  out  1  sticky underflow status
i_clr_sticky  in  1  clears both sticky bits
o_count  out  PTR_W+1  FIFO occupancy

Behaviour:
- Clocking: single clock i_clk; i_rst is synchronous and active-high.
- Reset: FIFO empty, o_count=0, o_valid=0, o_32_s=0, o_ov_flag=0, o_un_flag=0, o_special=0, o_sticky_ov=0, o_sticky_un=0.
- o_ready = (o_count < FIFO_DEPTH).
  - Registered occupancy only; no combinational path from i_ready.
  - A push is refused when full, even if a pop occurs in the same cycle.
- Push condition: i_valid & o_ready. Pop condition: head_valid & (!o_valid | i_ready).
  - Simultaneous push and pop leaves o_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- o_fpu_* are driven combinationally from the FIFO head. When the FIFO is empty they are driven with zeros.
- On pop, the output register loads the resolved result. o_valid is set, and holds its data stable until i_ready.
- Latency: an operation pushed in cycle t, into an empty FIFO with a free output register, has o_valid=1 in cycle t+2. Throughput is 1 op/cycle.
- Effective B sign: sb' = sign_b XOR i_add_sub[0].
- Special-case resolution, in priority order; a matching case sets o_special=1, forces o_ov_flag=o_un_flag=0, and ignores i_fpu_*:
  1. A or B is NaN (exp=FF, man≠0) -> 32'h7FC00000.
  2. Both Inf and sign_a≠sb' -> 32'h7FC00000.
  3. A is Inf -> A. B is Inf -> {sb', B[30:0]}.
  4. Both exp=0 -> {sign_a & sb', 31'b0}.
  5. exp_a=0 -> {sb', B[30:0]}. exp_b=0 -> A.
- Otherwise: o_32_s=i_fpu_32_s, o_ov_flag=i_fpu_ov_flag, o_un_flag=i_fpu_un_flag, o_special=0.
- Sticky bits:
  - On each load, o_sticky_ov |= loaded ov and o_sticky_un |= loaded un.
  - i_clr_sticky clears the previous value. A set from a load in the same cycle still takes effect.
- Reset mid-operation: queued and registered operations are dropped. No output handshake completes in the reset cycle.

Decomposition:
- Package fpu_pkg:
  - FP32 field widths: SIGN_BIT=31, EXP_W=8, MAN_W=23.
  - EXP_MAX=8'hFF, FP32_QNAN=32'h7FC00000.
  - fp32_t packed struct {sign, exp, man}.
  - OP_ADD/OP_SUB constants.
- Sub-module fpu_special_detect: combinational classification and special-result selection (inputs: a, b, op; outputs: special, result). The FIFO stays inline.

Test Plan:
- Push op=0, a=32'h3F800000, b=32'h40000000 at t; adder model returns 32'h40400000 -> o_valid=1 at t+2, o_32_s=32'h40400000, o_special=0.
- Hold i_ready=0 and push 6 ops back-to-back -> 5 accepted (1 in the output register, 4 in the FIFO), o_ready=0, o_count=4. Release i_ready -> 5 results drain in push order, one per cycle.
- op=1, a=32'h00000000, b=32'h3F800000 -> o_32_s=32'hBF800000, o_special=1, regardless of i_fpu_32_s.
- op=1, a=b=32'h7F800000 -> 32'h7FC00000. op=0, a=32'h7F800000, b=32'h3F800000 -> 32'h7F800000.
- Adder model asserts i_fpu_ov_flag on the 2nd of 3 ops -> o_ov_flag=1 only on the 2nd result; o_sticky_ov=1 until i_clr_sticky, then 0 the next cycle.
- Assert i_rst with 3 ops queued and o_valid=1 -> next cycle o_valid=0, o_count=0, o_ready=1, sticky bits 0.
